// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM state type for the text console writer.
package text_pkg;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 25;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AddrW = 11;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SO    = 8'h0E;  // inverse video on
  localparam logic [7:0] SI    = 8'h0F;  // inverse video off

  typedef enum logic [2:0] {
    StIdle,
    StPut,
    StClear,
    StScroll,
    StScrollClr
  } state_e;

  function automatic logic is_printable(logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Byte input handshake, text-RAM ports and status for the console writer.
interface text_console_writer_if
  import text_pkg::*;
;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [AddrW-1:0] ram_raddr;
  logic [7:0]       ram_rdata;
  logic             ram_we;
  logic [AddrW-1:0] ram_waddr;
  logic [7:0]       ram_wdata;
  logic [AddrW-1:0] cursor_pos;
  logic             busy;

  // Writer side.
  modport slave (
    input  in_valid, in_data, ram_rdata,
    output in_ready, ram_raddr, ram_we, ram_waddr, ram_wdata, cursor_pos, busy
  );

  // Byte source / RAM / observer side.
  modport master (
    output in_valid, in_data, ram_rdata,
    input  in_ready, ram_raddr, ram_we, ram_waddr, ram_wdata, cursor_pos, busy
  );

endinterface

// File: rtl/console_cursor.sv
// Row/column cursor with wrap, and a scroll request when the row would run off the screen.
module console_cursor
  import text_pkg::*;
#(
  parameter int unsigned Cols = COLS,
  parameter int unsigned Rows = ROWS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  input  logic             cr_i,
  input  logic             lf_i,
  input  logic             bs_i,
  input  logic             home_i,
  output logic [AddrW-1:0] pos_o,
  output logic             scroll_o
);

  localparam int unsigned RowW = $clog2(Rows);
  localparam int unsigned ColW = $clog2(Cols);
  localparam logic [RowW-1:0] LastRow = RowW'(Rows - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(Cols - 1);

  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [AddrW-1:0] pos_q, pos_d;

  // Next row/col; a move past the last row stays on it and raises scroll_o.
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    scroll_o = 1'b0;
    if (home_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_q == LastCol) begin
        col_d = '0;
        if (row_q == LastRow) scroll_o = 1'b1;
        else                  row_d    = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (lf_i) begin
      if (row_q == LastRow) scroll_o = 1'b1;
      else                  row_d    = row_q + 1'b1;
    end else if (cr_i) begin
      col_d = '0;
    end else if (bs_i && (col_q != '0)) begin
      col_d = col_q - 1'b1;
    end
    pos_d = AddrW'(row_d) * AddrW'(Cols) + AddrW'(col_d);
  end

  // Cursor state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
      pos_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/text_console_writer.sv
// Writes an ASCII byte stream into a text RAM: glyphs, cursor control, clear and scroll.
module text_console_writer
  import text_pkg::*;
#(
  parameter int unsigned COLS = text_pkg::COLS,
  parameter int unsigned ROWS = text_pkg::ROWS
) (
  input logic                  clk,
  input logic                  rst,
  text_console_writer_if.slave bus
);

  localparam int unsigned Cells = COLS * ROWS;
  localparam logic [AddrW-1:0] LastCell    = AddrW'(Cells - 1);
  localparam logic [AddrW-1:0] LastMove    = AddrW'(Cells - COLS - 1);
  localparam logic [AddrW-1:0] FirstBottom = AddrW'(Cells - COLS);
  localparam logic [AddrW-1:0] ColsA       = AddrW'(COLS);

  state_e           state_q;
  logic             in_ready_q, we_q, wsrc_q, inv_q, busy_q;
  logic [AddrW-1:0] waddr_q, raddr_q;
  logic [7:0]       wdata_q;

  logic             accept;
  logic [7:0]       byte_in;
  logic             cur_adv, cur_cr, cur_lf, cur_bs, cur_home, scroll_req;
  logic [AddrW-1:0] pos;

  // Handshake and cursor commands decoded from the accepted byte or the PUT cycle.
  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    byte_in  = bus.in_data;
    cur_adv  = (state_q == StPut);
    cur_cr   = accept && (byte_in == CR);
    cur_lf   = accept && (byte_in == LF);
    cur_bs   = accept && (byte_in == BS);
    cur_home = accept && (byte_in == FF);
  end

  console_cursor #(
    .Cols (COLS),
    .Rows (ROWS)
  ) u_cursor (
    .clk_i    (clk),
    .rst_i    (rst),
    .adv_i    (cur_adv),
    .cr_i     (cur_cr),
    .lf_i     (cur_lf),
    .bs_i     (cur_bs),
    .home_i   (cur_home),
    .pos_o    (pos),
    .scroll_o (scroll_req)
  );

  // Main FSM; outputs are set for the state being entered so ram_we tracks the writing states.
  // raddr rests at COLS outside a scroll so the first scroll read is already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wsrc_q     <= 1'b0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b1;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wdata_q    <= BLANK;
    end else if (scroll_req) begin
      state_q    <= StScroll;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      we_q       <= 1'b1;
      wsrc_q     <= 1'b1;
      waddr_q    <= '0;
      raddr_q    <= ColsA + 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_printable(byte_in)) begin
              state_q    <= StPut;
              in_ready_q <= 1'b0;
              we_q       <= 1'b1;
              waddr_q    <= pos;
              wdata_q    <= {inv_q, byte_in[6:0]};
            end else if (byte_in == FF) begin
              state_q    <= StClear;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              we_q       <= 1'b1;
              waddr_q    <= '0;
              wdata_q    <= BLANK;
            end else if (byte_in == SO) begin
              inv_q <= 1'b1;
            end else if (byte_in == SI) begin
              inv_q <= 1'b0;
            end
          end
        end
        StPut: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
          we_q       <= 1'b0;
        end
        StClear: begin
          if (!we_q) begin
            // First cycle after reset: start the sweep.
            we_q    <= 1'b1;
            waddr_q <= '0;
            wdata_q <= BLANK;
          end else if (waddr_q == LastCell) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            raddr_q    <= ColsA;
          end else begin
            waddr_q <= waddr_q + 1'b1;
          end
        end
        StScroll: begin
          if (waddr_q == LastMove) begin
            state_q <= StScrollClr;
            wsrc_q  <= 1'b0;
            wdata_q <= BLANK;
            waddr_q <= FirstBottom;
            raddr_q <= ColsA;
          end else begin
            waddr_q <= waddr_q + 1'b1;
            raddr_q <= (raddr_q == LastCell) ? ColsA : raddr_q + 1'b1;
          end
        end
        StScrollClr: begin
          if (waddr_q == LastCell) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
          end else begin
            waddr_q <= waddr_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StClear;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          we_q       <= 1'b0;
          wsrc_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.ram_raddr  = raddr_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_waddr  = waddr_q;
  // Scroll writes forward the RAM read data straight through.
  assign bus.ram_wdata  = wsrc_q ? bus.ram_rdata : wdata_q;
  assign bus.cursor_pos = pos;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural text RAM and write log.
module tb_text_console_writer;
  import text_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  text_console_writer_if bus ();

  text_console_writer #(
    .COLS (80),
    .ROWS (25)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:CELLS-1];
  logic [10:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];

  // Synchronous-read text RAM plus a log of every write strobe.
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wq_addr.push_back(bus.ram_waddr);
      wq_data.push_back(bus.ram_wdata);
      wq_cyc.push_back(cyc);
      mem[bus.ram_waddr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_raddr];
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic wait_ready(input string tag, input int limit);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, bus.in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready("send", 5000);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_clear_log(input string tag);
    int bad = 0;
    check({tag, "_count"}, wq_addr.size(), 2000);
    foreach (wq_addr[i]) begin
      if (wq_addr[i] != 11'(i) || wq_data[i] != 8'h20 || wq_cyc[i] != wq_cyc[0] + i) bad++;
    end
    check({tag, "_seq_errors"}, bad, 0);
  endtask

  initial begin
    int n;
    int bad;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values.
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_waddr", bus.ram_waddr, 0);
    check("rst_raddr", bus.ram_raddr, 0);
    check("rst_wdata", bus.ram_wdata, 8'h20);
    check("rst_cursor", bus.cursor_pos, 0);
    check("rst_busy", bus.busy, 1);

    // Post-reset clear.
    clear_log();
    rst = 1'b0;
    wait_ready("clear0", 3000);
    check_clear_log("clear0");
    check("clear0_cursor", bus.cursor_pos, 0);
    check("clear0_busy", bus.busy, 0);

    // "AB"
    clear_log();
    send_byte(8'h41);
    check("A_we", bus.ram_we, 1);
    check("A_waddr", bus.ram_waddr, 0);
    check("A_wdata", bus.ram_wdata, 8'h41);
    send_byte(8'h42);
    check("B_we", bus.ram_we, 1);
    check("B_waddr", bus.ram_waddr, 1);
    check("B_wdata", bus.ram_wdata, 8'h42);
    tick();
    check("AB_cursor", bus.cursor_pos, 2);
    check("AB_writes", wq_addr.size(), 2);

    // FF, then SO 'C' SI 'D'.
    clear_log();
    send_byte(FF);
    check("ff_cursor", bus.cursor_pos, 0);
    check("ff_busy", bus.busy, 1);
    wait_ready("clear1", 3000);
    check_clear_log("clear1");
    send_byte(SO);
    send_byte(8'h43);
    check("invC_waddr", bus.ram_waddr, 0);
    check("invC_wdata", bus.ram_wdata, 8'hC3);
    send_byte(SI);
    send_byte(8'h44);
    check("D_waddr", bus.ram_waddr, 1);
    check("D_wdata", bus.ram_wdata, 8'h44);

    // Inverse attribute survives a clear.
    send_byte(SO);
    send_byte(FF);
    wait_ready("clear2", 3000);
    send_byte(8'h45);
    check("invE_waddr", bus.ram_waddr, 0);
    check("invE_wdata", bus.ram_wdata, 8'hC5);
    send_byte(SI);

    // Build a screen: 'M' at 80, 'y' at 1920..1998, cursor ends at 1999.
    send_byte(FF);
    wait_ready("clear3", 3000);
    send_byte(LF);
    send_byte(8'h4D);
    send_byte(CR);
    for (int i = 0; i < 23; i++) send_byte(LF);
    wait_ready("row24", 10);
    check("row24_cursor", bus.cursor_pos, 1920);
    for (int i = 0; i < 79; i++) send_byte(8'h79);
    wait_ready("col79", 10);
    check("pre_scroll_cursor", bus.cursor_pos, 1999);

    // 'Z' at the last cell triggers a scroll.
    clear_log();
    send_byte(8'h5A);
    check("Z_we", bus.ram_we, 1);
    check("Z_waddr", bus.ram_waddr, 1999);
    check("Z_wdata", bus.ram_wdata, 8'h5A);
    n = 0;
    do begin
      tick();
      if (bus.busy === 1'b1) n++;
    end while (bus.busy === 1'b1 && n < 5000);
    check("scroll_busy_cycles", n, 2000);
    check("scroll_writes", wq_addr.size(), 2001);
    check("scroll_in_ready", bus.in_ready, 1);
    check("scroll_cursor", bus.cursor_pos, 1920);
    tick();
    check("scroll_cell0", mem[0], 8'h4D);
    check("scroll_cell80", mem[80], 8'h20);
    check("scroll_cell1840", mem[1840], 8'h79);
    check("scroll_cell1918", mem[1918], 8'h79);
    check("scroll_cell1919", mem[1919], 8'h5A);
    bad = 0;
    for (int a = 1920; a < 2000; a++) if (mem[a] !== 8'h20) bad++;
    check("scroll_bottom_blank", bad, 0);

    // LF on the last row scrolls; reset part way through.
    send_byte(LF);
    check("lf_scroll_busy", bus.busy, 1);
    check("lf_scroll_cursor", bus.cursor_pos, 1920);
    repeat (100) tick();
    check("mid_scroll_we", bus.ram_we, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", bus.ram_we, 0);
    check("mid_rst_busy", bus.busy, 1);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_cursor", bus.cursor_pos, 0);
    repeat (2) tick();
    clear_log();
    rst = 1'b0;
    wait_ready("clear4", 3000);
    check_clear_log("clear4");

    // CR/LF/BS from cursor 85.
    send_byte(LF);
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    wait_ready("c85", 10);
    check("c85_cursor", bus.cursor_pos, 85);
    send_byte(CR);
    check("cr_cursor", bus.cursor_pos, 80);
    send_byte(LF);
    check("lf_cursor", bus.cursor_pos, 160);
    send_byte(BS);
    check("bs_col0_cursor", bus.cursor_pos, 160);
    send_byte(8'h71);
    wait_ready("q", 10);
    check("q_cursor", bus.cursor_pos, 161);
    send_byte(BS);
    check("bs_cursor", bus.cursor_pos, 160);
    check("bs_no_erase", mem[160], 8'h71);

    // Dropped bytes.
    clear_log();
    send_byte(8'h07);
    send_byte(8'h7F);
    send_byte(8'hC1);
    repeat (3) tick();
    check("drop_writes", wq_addr.size(), 0);
    check("drop_cursor", bus.cursor_pos, 160);
    check("drop_in_ready", bus.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
